// File: rtl/signbcd_display_ctrl.sv
// signbcd_display_ctrl: signed 8-bit to sign+BCD converter with a 4-digit multiplexed 7-segment driver.
// Define LEADING_ZERO_BLANK_EN to blank the leading zeros of the hundreds and tens digits.
module signbcd_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] binary,
  output logic       busy,
  output logic       done,
  output logic       sign_b,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = BLANK;
    endcase
  endfunction

  logic [1:0] state, nxt;
  logic accept, sgn;
  logic [7:0] mag;
  logic [2:0] idx;
  logic [3:0] wh, wt, wo, at, ao;
  logic [2:0] ah;
  logic [CW-1:0] cnt;
  logic [1:0] dig, dig_nxt;
  logic [6:0] hund_seg, tens_seg, seg_nxt;

  always_comb begin
    accept = in_valid & in_ready;
    nxt = state == IDLE  ? (accept ? LOAD : IDLE) :
          state == LOAD  ? SHIFT :
          state == SHIFT ? (idx == 3'd0 ? DONE : SHIFT) : IDLE;
    ah = wh >= 4'd5 ? 3'(wh + 4'd3) : wh[2:0];
    at = wt >= 4'd5 ? wt + 4'd3 : wt;
    ao = wo >= 4'd5 ? wo + 4'd3 : wo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign_b   <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
      sgn      <= 1'b0;
      mag      <= '0;
      idx      <= '0;
      {wh, wt, wo} <= '0;
    end else begin
      state    <= nxt;
      in_ready <= nxt == IDLE;
      busy     <= nxt != IDLE;
      done     <= state == DONE;
      if (state == IDLE && accept) begin
        sgn <= binary[7];
        mag <= binary[7] ? 8'd0 - binary : binary;
      end
      if (state == LOAD) begin
        {wh, wt, wo} <= '0;
        idx <= 3'd7;
      end
      // hundreds never exceeds 2, so its adjusted MSB can be dropped on the shift
      if (state == SHIFT) begin
        {wh, wt, wo} <= {ah, at, ao, mag[idx]};
        idx <= idx - 3'd1;
      end
      if (state == DONE) begin
        sign_b   <= sgn;
        hundreds <= wh;
        tens     <= wt;
        ones     <= wo;
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    hund_seg = hundreds == 4'd0 ? BLANK : glyph(hundreds);
    tens_seg = (hundreds == 4'd0 && tens == 4'd0) ? BLANK : glyph(tens);
`else
    hund_seg = glyph(hundreds);
    tens_seg = glyph(tens);
`endif
    dig_nxt = dig + 2'd1;
    seg_nxt = dig_nxt == 2'd0 ? glyph(ones) :
              dig_nxt == 2'd1 ? tens_seg :
              dig_nxt == 2'd2 ? hund_seg : (sign_b ? MINUS : BLANK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dig <= 2'd0;
      an  <= 4'b1110;
      seg <= 7'b0000001;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      dig <= dig_nxt;
      an  <= ~(4'b0001 << dig_nxt);
      seg <= seg_nxt;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_signbcd_display_ctrl.sv
// tb_signbcd_display_ctrl: vector table, random conversions against an arithmetic model, and scan/abort sequences.
module tb_signbcd_display_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] binary = 8'd0;
  logic in_ready, busy, done, sign_b;
  logic [3:0] hundreds, tens, ones, an;
  logic [6:0] seg;
  int n_cmp = 0, n_err = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [7:0] bin;
    logic       s;
    logic [3:0] h, t, o;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  signbcd_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .binary(binary),
    .busy(busy), .done(done), .sign_b(sign_b), .hundreds(hundreds), .tens(tens),
    .ones(ones), .an(an), .seg(seg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d < 0 || d > 9) ? 7'h7F : g[d];
  endfunction

  function automatic logic [6:0] exp_seg(input int slot, input logic s, input int h, t, o);
    case (slot)
      0: return glyph(o);
      1: return (LZB && h == 0 && t == 0) ? 7'h7F : glyph(t);
      2: return (LZB && h == 0) ? 7'h7F : glyph(h);
      default: return s ? 7'h3F : 7'h7F;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ready_wait", in_ready, 1);
  endtask

  task automatic run(input logic [7:0] v, output int lat);
    wait_ready();
    in_valid = 1'b1;
    binary = v;
    tick();
    in_valid = 1'b0;
    binary = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic s,
                              input logic [3:0] h, t, o);
    chk({tag, ".latency"}, lat, 10);
    chk({tag, ".sign_b"}, sign_b, s);
    chk({tag, ".hundreds"}, hundreds, h);
    chk({tag, ".tens"}, tens, t);
    chk({tag, ".ones"}, ones, o);
    tick();
    chk({tag, ".done_width"}, done, 0);
  endtask

  task automatic display_check(input string tag, input logic s, input int h, t, o);
    logic [3:0] prev, ea;
    logic [6:0] s0;
    bit found = 0, stable;
    prev = an;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (an == 4'b1110 && prev != 4'b1110) begin
        found = 1;
        break;
      end
      prev = an;
    end
    chk({tag, ".scan_sync"}, found, 1);
    for (int k = 0; k < 5; k++) begin
      ea = 4'b1111 ^ (4'b0001 << (k % 4));
      chk({tag, ".an"}, an, ea);
      chk({tag, ".seg"}, seg, exp_seg(k % 4, s, h, t, o));
      s0 = seg;
      stable = 1;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (an !== ea || seg !== s0) stable = 0;
      end
      chk({tag, ".slot_hold"}, stable, 1);
      tick();
    end
  endtask

  initial begin
    int lat, sv, m, cnt;
    logic [7:0] v;
    vt[0] = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
    vt[1] = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
    vt[2] = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
    vt[3] = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
    vt[4] = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
    vt[5] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};

    tick(); tick(); tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", {sign_b, hundreds, tens, ones}, 0);
    chk("rst.an", an, 4'b1110);
    chk("rst.seg", seg, 7'b0000001);
    rst = 1'b0;
    tick();
    chk("rst.ready_rise", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run(vt[i].bin, lat);
      check_result($sformatf("vec%0d", i), lat, vt[i].s, vt[i].h, vt[i].t, vt[i].o);
    end

    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom_range(0, 255));
      sv = $signed(v);
      m = sv < 0 ? -sv : sv;
      run(v, lat);
      check_result($sformatf("rand%0d", i), lat, sv < 0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10));
    end

    // in_valid held through busy with a changing binary: only the first value converts
    wait_ready();
    in_valid = 1'b1;
    binary = 8'h05;
    tick();
    binary = 8'h09;
    lat = 0;
    cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        in_valid = 1'b0;
        break;
      end
      if (in_ready !== 1'b0) cnt++;
    end
    chk("hold.ready_while_busy", cnt, 0);
    check_result("hold", lat, 1'b0, 4'd0, 4'd0, 4'd5);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("hold.no_requeue", cnt, 0);
    run(8'h09, lat);
    check_result("hold2", lat, 1'b0, 4'd0, 4'd0, 4'd9);

    // abort on the 4th SHIFT cycle of 100
    run(8'h80, lat);
    check_result("pre_abort", lat, 1'b1, 4'd1, 4'd2, 4'd8);
    wait_ready();
    in_valid = 1'b1;
    binary = 8'h64;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort.result", {sign_b, hundreds, tens, ones}, 0);
    chk("abort.flags", {in_ready, busy, done}, 0);
    chk("abort.an", an, 4'b1110);
    chk("abort.seg", seg, 7'b0000001);
    rst = 1'b0;
    tick();
    chk("abort.ready_rise", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    chk("abort.no_done", cnt, 0);
    chk("abort.result_held", {sign_b, hundreds, tens, ones}, 0);

    run(8'hF9, lat);
    check_result("m7", lat, 1'b1, 4'd0, 4'd0, 4'd7);
    display_check("scan_m7", 1'b1, 0, 0, 7);
    run(8'd45, lat);
    check_result("p45", lat, 1'b0, 4'd0, 4'd4, 4'd5);
    display_check("scan_p45", 1'b0, 0, 4, 5);
    run(8'h80, lat);
    check_result("m128", lat, 1'b1, 4'd1, 4'd2, 4'd8);
    display_check("scan_m128", 1'b1, 1, 2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
